// File: rtl/ps2_pkg.sv
// ps2_pkg
//   Shared definitions for the PS/2 scan-code receiver:
//   - frame FSM state encoding
//   - PS/2 prefix byte constants (extended / break)
//   - packed event layout stored in the event FIFO
//   - odd-parity helper used by the frame FSM
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int EVT_W = 10;

  // Event word as held in the FIFO: {ext, brk, code}.
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  // True when the 8 data bits plus the parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo
//   Show-ahead event queue for decoded key events. The head entry is visible
//   on dout whenever empty is low; dout reads as zero while empty.
//   A push while full is rejected (drop pulses) unless a pop happens in the
//   same cycle, in which case both are accepted.
// Ports
//   clk, resetn : clock, synchronous active-low reset
//   push, din   : write request and event word
//   pop         : remove head entry (ignored while empty)
//   full, empty : occupancy status
//   dout        : head entry (show-ahead)
//   drop        : a push was rejected this cycle because the queue was full
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4   // power of two, at least 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [EVT_W-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [EVT_W-1:0] dout,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);

  logic [EVT_W-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push & (~full | do_pop);
  assign drop    = push & ~do_push;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; the head is masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  assign dout = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx
//   PS/2 keyboard receiver: synchronises and de-glitches the keyboard clock,
//   deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop),
//   folds E0/F0 prefixes into {ext, break, code} events and queues them.
// Ports
//   clk, resetn      : system clock, synchronous active-low reset
//   PS2Clk, PS2Data  : asynchronous keyboard lines, idle high
//   rd_en            : pop the head event (ignored when key_valid is low)
//   err_clr          : clear frame_err and overflow
//   key_valid        : event queue non-empty
//   key_code         : head event scan code
//   key_break        : head event is a key release
//   key_ext          : head event is an extended key
//   frame_err        : sticky, framing/parity/timeout error seen
//   overflow         : sticky, an event was dropped on a full queue
module ps2_scan_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       PS2Clk,
  input  logic       PS2Data,
  input  logic       rd_en,
  input  logic       err_clr,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_break,
  output logic       key_ext,
  output logic       frame_err,
  output logic       overflow
);

  localparam int              FW        = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int              TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0]   FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0]   TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  // ---------------------------------------------------------------- sync
  logic [1:0] clk_sync_q;
  logic [1:0] data_sync_q;
  logic       clk_s, data_s;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], PS2Clk};
      data_sync_q <= {data_sync_q[0], PS2Data};
    end
  end

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];

  // -------------------------------------------------------------- filter
  // The filtered level flips on the FILTER_LEN-th consecutive sample that
  // disagrees with it; any agreeing sample restarts the run.
  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          strobe;

  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    strobe     = 1'b0;
    if (clk_s != filt_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        filt_d = clk_s;
        strobe = ~clk_s;
      end else begin
        filt_cnt_d = filt_cnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  // ----------------------------------------------------------- frame FSM
  ps2_state_e    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_bad_q, par_bad_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          byte_vld_q, byte_vld_d;
  logic [7:0]    byte_q;
  logic          abort_q, abort_d;
  logic          err_set;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_bad_q  <= 1'b0;
      to_cnt_q   <= '0;
      byte_vld_q <= 1'b0;
      byte_q     <= '0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_bad_q  <= par_bad_d;
      to_cnt_q   <= to_cnt_d;
      byte_vld_q <= byte_vld_d;
      byte_q     <= shift_q;
      abort_q    <= abort_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_bad_d  = par_bad_q;
    byte_vld_d = 1'b0;
    abort_d    = 1'b0;
    err_set    = 1'b0;

    // Idle time is only measured while a frame is open.
    if (state_q == ST_IDLE || strobe) to_cnt_d = '0;
    else                              to_cnt_d = to_cnt_q + TW'(1);

    case (state_q)
      ST_IDLE: begin
        if (strobe) begin
          if (!data_s) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
            par_bad_d = 1'b0;
          end else begin
            err_set = 1'b1;
            abort_d = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (strobe) begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (strobe) begin
          par_bad_d = ~odd_parity_ok(shift_q, data_s);
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (strobe) begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
          if (data_s && !par_bad_q) begin
            byte_vld_d = 1'b1;
          end else begin
            err_set = 1'b1;
            abort_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE && !strobe && to_cnt_q == TO_LAST) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      err_set   = 1'b1;
      abort_d   = 1'b1;
    end
  end

  // ------------------------------------------------------------- decoder
  // byte_q is the shift register captured on the stop strobe, so it lines up
  // with byte_vld_q one cycle later.
  logic     ext_pend_q, ext_pend_d;
  logic     brk_pend_q, brk_pend_d;
  logic     evt_push;
  ps2_evt_t evt_in;

  always_comb begin
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    evt_push   = 1'b0;
    evt_in     = '{ext: ext_pend_q, brk: brk_pend_q, code: byte_q};
    if (abort_q) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end else if (byte_vld_q) begin
      if (byte_q == PS2_EXT) begin
        ext_pend_d = 1'b1;
      end else if (byte_q == PS2_BRK) begin
        brk_pend_d = 1'b1;
      end else begin
        evt_push   = 1'b1;
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- FIFO
  logic             fifo_full, fifo_empty, fifo_drop;
  logic [EVT_W-1:0] fifo_dout;
  ps2_evt_t         head_evt;

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (evt_push),
    .din    (evt_in),
    .pop    (rd_en),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .dout   (fifo_dout),
    .drop   (fifo_drop)
  );

  // --------------------------------------------------------- sticky flags
  // A set in the same cycle as err_clr wins.
  logic frame_err_q, frame_err_d;
  logic overflow_q, overflow_d;

  assign frame_err_d = err_set   | (frame_err_q & ~err_clr);
  assign overflow_d  = fifo_drop | (overflow_q  & ~err_clr);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  // -------------------------------------------------------------- outputs
  assign head_evt  = ps2_evt_t'(fifo_dout);
  assign key_valid = ~fifo_empty;
  assign key_code  = head_evt.code;
  assign key_break = head_evt.brk;
  assign key_ext   = head_evt.ext;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

  // fifo_full is only consumed inside the FIFO's own accept logic.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_ps2_scan_rx.sv
module tb_ps2_scan_rx;

  localparam int FL    = 4;
  localparam int TO    = 300;
  localparam int DEPTH = 4;
  localparam int H     = 10;   // PS/2 half period in clk cycles

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       PS2Clk = 1'b1;
  logic       PS2Data = 1'b1;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_break;
  logic       key_ext;
  logic       frame_err;
  logic       overflow;

  always #5 clk = ~clk;

  ps2_scan_rx #(
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TO),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .PS2Clk    (PS2Clk),
    .PS2Data   (PS2Data),
    .rd_en     (rd_en),
    .err_clr   (err_clr),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_break (key_break),
    .key_ext   (key_ext),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [9:0] exp_q[$];          // expected {ext, brk, code}
  bit         drain_en = 1'b1;
  bit         force_rd = 1'b0;
  bit         mdl_ext  = 1'b0;
  bit         mdl_brk  = 1'b0;
  bit         mdl_ovf  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Reference decoder: what a host should see for each received byte.
  task automatic model_byte(input logic [7:0] b, input bit good);
    if (!good) begin
      mdl_ext = 1'b0;
      mdl_brk = 1'b0;
    end else if (b == 8'hE0) begin
      mdl_ext = 1'b1;
    end else if (b == 8'hF0) begin
      mdl_brk = 1'b1;
    end else begin
      if (!drain_en && exp_q.size() >= DEPTH) mdl_ovf = 1'b1;
      else exp_q.push_back({mdl_ext, mdl_brk, b});
      mdl_ext = 1'b0;
      mdl_brk = 1'b0;
    end
  endtask

  // Monitor: pops and compares every event the DUT presents.
  initial begin
    logic [9:0] exp_evt;
    forever begin
      @(negedge clk);
      if (drain_en && key_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event: got %h, required none", {key_ext, key_break, key_code});
        end else begin
          exp_evt = exp_q.pop_front();
          check("event", {22'd0, key_ext, key_break, key_code}, {22'd0, exp_evt});
        end
        rd_en = 1'b1;
      end else begin
        rd_en = force_rd;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required test end");
    $fatal(1, "watchdog");
  end

  task automatic ps2_bit(input logic v, input bit measure, output int lat);
    lat = -1;
    PS2Data = v;
    repeat (H) @(negedge clk);
    PS2Clk = 1'b0;
    for (int k = 1; k <= H; k++) begin
      @(negedge clk);
      if (measure && lat < 0 && key_valid) lat = k;
    end
    PS2Clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit measure, output int lat);
    int   d;
    logic p;
    p = ~(^b) ^ bad_par;
    ps2_bit(1'b0, 1'b0, d);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0, d);
    ps2_bit(p, 1'b0, d);
    ps2_bit(~bad_stop, measure, lat);
    PS2Data = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  task automatic send_good(input logic [7:0] b);
    int lat;
    model_byte(b, 1'b1);
    send_frame(b, 1'b0, 1'b0, 1'b0, lat);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    int d;
    ps2_bit(1'b0, 1'b0, d);
    for (int i = 0; i < nbits; i++) ps2_bit(b[i], 1'b0, d);
    PS2Data = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while ((exp_q.size() != 0 || key_valid) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    mdl_ext = 1'b0;
    mdl_brk = 1'b0;
    mdl_ovf = 1'b0;
    exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    int lat;
    do_reset();
    check("rst_key_valid", key_valid, 0);
    check("rst_key_code",  key_code,  0);
    check("rst_key_break", key_break, 0);
    check("rst_key_ext",   key_ext,   0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overflow",  overflow,  0);

    // Plain make code, with latency from the stop strobe.
    model_byte(8'h1C, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b1, lat);
    check("make_latency", lat, FL + 3);
    wait_drain("make_drained");
    check("make_no_err", frame_err, 0);

    // Prefix folding.
    send_good(8'hF0); send_good(8'h1C);
    send_good(8'hE0); send_good(8'hF0); send_good(8'h75);
    wait_drain("prefix_drained");

    // Parity error.
    model_byte(8'h1C, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0, lat);
    check("parity_err", frame_err, 1);
    pulse_clr();
    check("parity_err_cleared", frame_err, 0);
    wait_drain("parity_drained");

    // Timeout mid-frame also drops a pending E0.
    send_good(8'hE0);
    send_partial(8'h5A, 5);
    model_byte(8'h00, 1'b0);
    repeat (TO + 50) @(negedge clk);
    check("timeout_err", frame_err, 1);
    pulse_clr();
    check("timeout_err_cleared", frame_err, 0);
    send_good(8'h29);
    wait_drain("timeout_drained");

    // Short clock glitch with data high must not look like a start bit.
    PS2Data = 1'b1;
    @(negedge clk);
    PS2Clk = 1'b0;
    repeat (FL - 1) @(negedge clk);
    PS2Clk = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_no_err", frame_err, 0);
    check("glitch_no_event", key_valid, 0);
    send_good(8'h1C);
    wait_drain("glitch_drained");

    // Reset mid-frame discards the partial byte and pending prefix quietly.
    send_good(8'hE0);
    send_partial(8'h33, 3);
    do_reset();
    check("midrst_no_err", frame_err, 0);
    check("midrst_no_event", key_valid, 0);
    send_good(8'h1C);
    wait_drain("midrst_drained");

    // Overflow: five makes with no reads.
    drain_en = 1'b0;
    send_good(8'h15); send_good(8'h16); send_good(8'h1D);
    send_good(8'h24); send_good(8'h2D);
    check("ovf_flag", overflow, mdl_ovf);
    check("ovf_valid", key_valid, 1);
    drain_en = 1'b1;
    wait_drain("ovf_drained");
    @(negedge clk);
    force_rd = 1'b1;
    repeat (3) @(negedge clk);
    force_rd = 1'b0;
    check("rd_empty_valid", key_valid, 0);
    send_good(8'h3C);
    wait_drain("rd_empty_drained");
    pulse_clr();
    check("ovf_cleared", overflow, 0);
    mdl_ovf = 1'b0;

    // Randomised frames against the reference decoder.
    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      int         kind, err;
      kind = $urandom_range(0, 9);
      err  = $urandom_range(0, 7);
      if (kind < 2)       b = 8'hE0;
      else if (kind == 2) b = 8'hF0;
      else                b = 8'($urandom_range(0, 255));
      model_byte(b, err > 1);
      send_frame(b, err == 0, err == 1, 1'b0, lat);
      if (err <= 1) begin
        check("rand_err_set", frame_err, 1);
        pulse_clr();
        check("rand_err_clr", frame_err, 0);
      end
      repeat ($urandom_range(0, 15)) @(negedge clk);
    end
    wait_drain("rand_drained");
    check("rand_no_ovf", overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_scan_rx.md
PS2_SCAN_RX -- requirements
Module: ps2_scan_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 4: consecutive equal samples of synchronised PS2Clk needed to change its filtered level.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000: clk cycles without a PS2Clk falling edge before an in-progress frame is aborted.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, power of two: event queue depth.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port PS2Clk  input  1  asynchronous keyboard clock, idle high.
REQ-007 SHALL have port PS2Data  input  1  asynchronous keyboard data, idle high.
REQ-008 SHALL have port rd_en  input  1  pop head event when key_valid is high.
REQ-009 SHALL have port err_clr  input  1  clear sticky error flags.
REQ-010 SHALL have port key_valid  output  1  FIFO non-empty.
REQ-011 SHALL have port key_code  output  8  head event scan code (show-ahead).
REQ-012 SHALL have port key_break  output  1  head event is a release (F0-prefixed).
REQ-013 SHALL have port key_ext  output  1  head event is extended (E0-prefixed).
REQ-014 SHALL have port frame_err  output  1  sticky: start, parity, stop or timeout error seen.
REQ-015 SHALL have port overflow  output  1  sticky: event dropped because FIFO full.

Function
REQ-016 SHALL pass PS2Clk and PS2Data each through a 2-flop synchroniser before any use.
REQ-017 SHALL update filtered clock only after FILTER_LEN consecutive identical synchronised samples; a 1-to-0 filtered transition is the sample strobe; shorter glitches produce no strobe.
REQ-018 SHALL run frame FSM IDLE -> DATA -> PARITY -> STOP -> IDLE, advancing only on strobes, sampling synchronised PS2Data.
REQ-019 In IDLE, strobe with data 0 SHALL enter DATA with bit count 0; data 1 SHALL set frame_err and remain IDLE.
REQ-020 In DATA, SHALL shift 8 bits LSB-first, entering PARITY after the eighth.
REQ-021 In PARITY, SHALL check odd parity over 8 data bits plus parity bit; mismatch marks the frame bad.
REQ-022 In STOP, data 1 with good parity SHALL deliver the byte to the decoder; otherwise frame_err sets and the byte is discarded; either way return to IDLE.
REQ-023 In any non-IDLE state, TIMEOUT_CYCLES cycles since the last strobe SHALL force IDLE, set frame_err, discard partial byte.
REQ-024 Decoder: byte 0xE0 SHALL set pending-ext; 0xF0 SHALL set pending-break; any other byte (incl. 0xE1) SHALL push {ext, break, code} and clear both pending flags.
REQ-025 A discarded/errored frame SHALL clear both pending flags.
REQ-026 Latency: stop strobe in cycle N -> decode register N+1 -> key_valid and head visible in cycle N+2 when FIFO was empty.
REQ-027 Push when full SHALL drop the new event and set overflow; simultaneous push and pop when full SHALL accept both.
REQ-028 rd_en while empty SHALL be ignored with no pointer change.
REQ-029 Sticky flags: set-event and err_clr in same cycle SHALL leave flag set.

Reset
REQ-030 resetn low at a clk edge SHALL set FSM IDLE, bit count 0, filtered clock 1, synchroniser flops 1, pending flags 0, FIFO empty, key_valid/key_code/key_break/key_ext/frame_err/overflow 0, timeout counter 0.
REQ-031 Reset mid-frame SHALL discard the partial byte with no error flagged.

Structure
REQ-032 Package ps2_pkg SHALL hold the FSM state encoding and constants PS2_EXT = 8'hE0, PS2_BRK = 8'hF0.
REQ-033 FIFO SHALL be sub-module ps2_evt_fifo (10-bit entries, show-ahead, full/empty); all else in ps2_scan_rx.

Verification
REQ-034 Frame 0x1C, parity 0, stop 1 -> one event code 0x1C, break 0, ext 0, key_valid at stop strobe +2.
REQ-035 Frames F0,1C -> single event code 0x1C, break 1; frames E0,F0,75 -> code 0x75, ext 1, break 1.
REQ-036 Frame 0x1C with parity 1 -> no event, frame_err 1; err_clr pulse -> frame_err 0.
REQ-037 Five data bits then clock held high TIMEOUT_CYCLES -> FSM IDLE, frame_err 1; next valid 0x29 frame -> event 0x29.
REQ-038 Five make codes with rd_en low, depth 4 -> four events in order, fifth dropped, overflow 1.
REQ-039 PS2Clk glitch low for FILTER_LEN-1 cycles in IDLE -> no strobe, no state change, no error.
